// File: rtl/button_arbiter.sv
// -----------------------------------------------------------------------------
// button_arbiter
// Synchronizes and debounces N raw push-button levels, turns each accepted
// press (rising debounced level) into a queued event, and hands the queued
// events one per cycle to a consumer through a round-robin arbiter.
// A press that arrives while the same button still has an unserved event
// is flagged in a sticky per-button overflow bit.
// -----------------------------------------------------------------------------
module button_arbiter #(
   parameter int N        = 4,   // number of buttons, 2..8
   parameter int DEBOUNCE = 4    // stable cycles before a level change is accepted, 1..255
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [N-1:0]         button,
   input  logic                 ready,
   output logic                 pulse,
   output logic [$clog2(N)-1:0] pulse_id,
   output logic [N-1:0]         pending,
   output logic [N-1:0]         overflow
);

   localparam int IW = $clog2(N);
   // The counter never holds DEBOUNCE itself (it clears on the accepting
   // edge), but sizing for DEBOUNCE+1 keeps DEBOUNCE=1 at a legal 1-bit width.
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [N-1:0]    r_sync1;        // first synchronizer stage
   logic [N-1:0]    r_sync2;        // second synchronizer stage (s2)
   logic [N-1:0]    r_deb;          // accepted (debounced) level
   logic [N-1:0]    r_deb_prev;     // debounced level one cycle earlier
   logic [CW-1:0]   r_cnt [N];      // per-button disagreement run length
   logic [N-1:0]    r_pending;      // one queued event per button
   logic [N-1:0]    r_overflow;     // sticky: an event was lost
   logic            r_pulse;
   logic [IW-1:0]   r_pulse_id;
   logic [IW-1:0]   r_last_grant;   // round-robin pointer

   // ---------------------------------------------------------------------------
   // Combinational arbitration signals
   // ---------------------------------------------------------------------------
   logic [N-1:0]    w_rise;         // debounced level went 0 -> 1 last edge
   logic            w_grant_valid;  // a grant happens on the coming edge
   logic [IW-1:0]   w_grant_idx;    // which button is granted
   logic [N-1:0]    w_grant_vec;    // one-hot form of w_grant_idx (or zero)

   // Index of the button visited 'offset' steps after 'last' in the ring.
   function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] last,
                                               input int            offset);
      int sum;
      sum = int'(last) + 1 + offset;
      return IW'(sum % N);
   endfunction

   // Two-flop synchronizer for the asynchronous button levels.
   // NOTE: every clocked block uses non-blocking (<=) so all flops sample the
   // values from before the edge; blocking here would collapse the two stages.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= button;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce: a new level is accepted after DEBOUNCE consecutive disagreeing
   // samples; any agreeing sample restarts the run.
   // NOTE: the counter array is plain flops, not a RAM, so it is reset along
   // with everything else; a mid-debounce reset must forget partial runs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_deb      <= '0;
         r_deb_prev <= '0;
         for (int i = 0; i < N; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_deb_prev <= r_deb;
         for (int i = 0; i < N; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               // This edge would take the run to DEBOUNCE: accept the level.
               r_deb[i] <= r_sync2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Press detection: only the 0 -> 1 transition of the accepted level counts.
   assign w_rise = r_deb & ~r_deb_prev;

   // Round-robin search starting one past the last granted button. Walking
   // the ring from the far end back towards the start lets the nearest
   // pending button overwrite any farther one without a separate found flag.
   // NOTE: every always_comb output gets a default before any conditional
   // logic, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_idx   = '0;
      w_grant_vec   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (r_pending[rr_index(r_last_grant, k)]) begin
            w_grant_valid = ready;
            w_grant_idx   = rr_index(r_last_grant, k);
         end
      end
      if (w_grant_valid) begin
         w_grant_vec[w_grant_idx] = 1'b1;
      end
   end

   // Event queue: the granted bit clears, a fresh press sets its bit. A press
   // on a bit that stays pending (not granted this edge) loses an event.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pending  <= '0;
         r_overflow <= '0;
      end else begin
         r_pending  <= (r_pending & ~w_grant_vec) | w_rise;
         r_overflow <= r_overflow | (w_rise & r_pending & ~w_grant_vec);
      end
   end

   // Registered pulse output and round-robin pointer; pulse_id and the
   // pointer only move on a grant, so pulse_id holds while pulse is low.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pulse      <= 1'b0;
         r_pulse_id   <= '0;
         r_last_grant <= IW'(N - 1);   // button 0 is searched first
      end else if (w_grant_valid) begin
         r_pulse      <= 1'b1;
         r_pulse_id   <= w_grant_idx;
         r_last_grant <= w_grant_idx;
      end else begin
         r_pulse      <= 1'b0;
      end
   end

   assign pulse    = r_pulse;
   assign pulse_id = r_pulse_id;
   assign pending  = r_pending;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_button_arbiter.sv
// -----------------------------------------------------------------------------
// tb_button_arbiter
// Scoreboard bench for button_arbiter (N=4, DEBOUNCE=4). A reference model
// works from sampled button history: a level is accepted when the last
// DEBOUNCE synchronized samples all disagree with it, presses become queued
// events, and the nearest pending button in ring order after the last grant
// is served. Expected pulses go into a queue that a negedge monitor drains.
// -----------------------------------------------------------------------------
module tb_button_arbiter;

   localparam int N  = 4;
   localparam int D  = 4;
   localparam int IW = $clog2(N);

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [N-1:0]  button = '0;
   logic          ready = 1'b1;
   logic          pulse;
   logic [IW-1:0] pulse_id;
   logic [N-1:0]  pending;
   logic [N-1:0]  overflow;

   button_arbiter #(.N(N), .DEBOUNCE(D)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .button   (button),
      .ready    (ready),
      .pulse    (pulse),
      .pulse_id (pulse_id),
      .pending  (pending),
      .overflow (overflow)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   typedef struct { int cyc; int id; } exp_t;
   exp_t          sb[$];

   logic [N-1:0]  hq[$];               // sampled button vectors, newest last
   logic [N-1:0]  deb_m      = '0;     // accepted level after the last edge
   logic [N-1:0]  deb_prev_m = '0;     // accepted level one edge earlier
   logic [N-1:0]  pend_m     = '0;
   logic [N-1:0]  ovf_m      = '0;
   int            last_m     = N - 1;
   int            id_m       = 0;
   int            cyc        = 0;

   task automatic model_reset();
      hq.delete();
      for (int j = 0; j < D + 2; j++) hq.push_back('0);
      deb_m = '0; deb_prev_m = '0; pend_m = '0; ovf_m = '0;
      last_m = N - 1; id_m = 0;
      sb.delete();
   endtask

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         model_reset();
      end else begin
         logic [N-1:0] rise, gvec;
         int           best, bestd;
         cyc++;
         rise = deb_m & ~deb_prev_m;
         // Serve the pending button closest after the last grant in ring order.
         best = -1; bestd = N;
         for (int i = 0; i < N; i++) begin
            if (pend_m[i] && ((i - last_m - 1 + 2 * N) % N) < bestd) begin
               bestd = (i - last_m - 1 + 2 * N) % N;
               best  = i;
            end
         end
         gvec = '0;
         if (ready && best >= 0) begin
            gvec[best] = 1'b1;
            last_m = best;
            id_m   = best;
            sb.push_back('{cyc: cyc, id: best});
         end
         ovf_m  = ovf_m | (rise & pend_m & ~gvec);
         pend_m = (pend_m & ~gvec) | rise;
         // The value the second synchronizer stage shows at edge e is the
         // button sampled at edge e-2, i.e. hq[size-2]; a level flips when
         // the last D such samples all disagree with it.
         deb_prev_m = deb_m;
         for (int i = 0; i < N; i++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) begin
               if (hq[hq.size() - 2 - j][i] == deb_m[i]) all_diff = 1'b0;
            end
            if (all_diff) deb_m[i] = ~deb_m[i];
         end
         hq.push_back(button);
         if (hq.size() > D + 2) void'(hq.pop_front());
      end
   end

   // ---------------------------------------------------------------------------
   // Monitor: drains expected pulses and compares visible state each cycle
   // ---------------------------------------------------------------------------
   always @(negedge CLK) begin
      exp_t e;
      if (pulse === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", 32'(pulse), 32'd0);
         end else begin
            e = sb.pop_front();
            check("pulse_cycle", 32'(cyc), 32'(e.cyc));
            check("pulse_id", 32'(pulse_id), 32'(e.id));
         end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         check("missed_pulse", 32'(pulse), 32'd1);
      end
      check("pending", 32'(pending), 32'(pend_m));
      check("overflow", 32'(overflow), 32'(ovf_m));
      check("pulse_id_hold", 32'(pulse_id), 32'(id_m));
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic cycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Reset pulsed between edges; outputs must clear without waiting for CLK.
   task automatic mid_reset();
      @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      check("rst_pulse", 32'(pulse), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_pulse_id", 32'(pulse_id), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      logic [N-1:0] lvl;
      model_reset();
      cycles(3);
      check("reset_pulse", 32'(pulse), 32'd0);
      check("reset_pending", 32'(pending), 32'd0);
      RST = 1'b0;

      // Single press on button 2, then release (no pulse on the fall).
      button = 4'b0100; cycles(14);
      button = 4'b0000; cycles(14);

      // Bounce on button 0: 3 high, 1 low, then held.
      button = 4'b0001; cycles(3);
      button = 4'b0000; cycles(1);
      button = 4'b0001; cycles(14);
      button = 4'b0000; cycles(12);

      // Simultaneous presses, twice, to exercise the ring wrap.
      repeat (2) begin
         button = 4'b1011; cycles(12);
         button = 4'b0000; cycles(12);
      end

      // Backpressure: press, release, press while the consumer stalls.
      ready = 1'b0;
      button = 4'b0010; cycles(9);
      button = 4'b0000; cycles(9);
      button = 4'b0010; cycles(9);
      check("bp_pending", 32'(pending), 32'h2);
      check("bp_overflow", 32'(overflow), 32'h2);
      ready = 1'b1; cycles(4);
      button = 4'b0000; cycles(10);

      // Reset with events pending and buttons already released.
      ready = 1'b0;
      button = 4'b1010; cycles(10);
      button = 4'b0000; cycles(10);
      check("pre_reset_pending", 32'(pending), 32'ha);
      mid_reset();
      ready = 1'b1; cycles(15);

      // Reset mid-debounce, then a button held across reset release.
      button = 4'b0001; cycles(3);
      mid_reset();
      cycles(14);
      button = 4'b0000; cycles(12);

      // Randomized segments with varying stall ratio and activity.
      lvl = '0;
      for (int seg = 0; seg < 24; seg++) begin
         int rdy_pct, tog_pct;
         rdy_pct = $urandom_range(10, 100);
         tog_pct = $urandom_range(2, 15);
         for (int c = 0; c < 100; c++) begin
            logic [N-1:0] drive;
            for (int i = 0; i < N; i++) begin
               if ($urandom_range(0, 99) < tog_pct) lvl[i] = ~lvl[i];
            end
            drive = lvl;
            if ($urandom_range(0, 29) == 0) drive[$urandom_range(0, N - 1)] ^= 1'b1;
            button = drive;
            ready  = ($urandom_range(0, 99) < rdy_pct);
            @(negedge CLK);
         end
         if ($urandom_range(0, 5) == 0) mid_reset();
      end

      // Drain: everything released, consumer always ready.
      button = '0; ready = 1'b1;
      cycles(40);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      check("drained_pending", 32'(pending), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/button_arbiter.md
BUTTON_ARBITER -- requirements
Module: button_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning number of button inputs (2..8).
REQ-002 The block SHALL have parameter DEBOUNCE, default 4, meaning consecutive stable cycles required before a level change is accepted (1..255).
REQ-003 The block SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port button  input  N  raw asynchronous button levels, 1 = pressed.
REQ-006 The block SHALL have port ready  input  1  consumer can accept a pulse this cycle.
REQ-007 The block SHALL have port pulse  output  1  one-cycle press event, registered.
REQ-008 The block SHALL have port pulse_id  output  clog2(N)  index of the button owning the current pulse, registered.
REQ-009 The block SHALL have port pending  output  N  per-button queued-event flags.
REQ-010 The block SHALL have port overflow  output  N  sticky per-button event-lost flags.

Function
REQ-011 Each button bit SHALL pass through a 2-flop synchronizer; the second stage is s2[i].
REQ-012 Per button, a debounce counter SHALL increment each cycle s2[i] != deb[i] and clear to 0 whenever s2[i] == deb[i].
REQ-013 deb[i] SHALL take the value of s2[i] on the edge where the counter would reach DEBOUNCE; the counter clears on that same edge.
REQ-014 A rising edge of deb[i] (deb[i]=1, previous deb[i]=0) SHALL set pending[i] on the next edge; falling edges SHALL produce no event.
REQ-015 Event latency: with edge 0 as the first edge sampling the new stable level, deb[i] SHALL rise at edge 1+DEBOUNCE, pending[i] at edge 2+DEBOUNCE, and pulse at edge 3+DEBOUNCE if ready=1 and no other button wins.
REQ-016 Any pending bit set while ready=1 SHALL make pulse=1 for exactly one cycle after the next edge; pulse_id SHALL name the granted button, and that pending bit SHALL clear on the same edge.
REQ-017 With ready=0, pulse SHALL be 0 and all pending bits SHALL hold; no event is lost while waiting.
REQ-018 Grants SHALL be round-robin: the search starts at last_grant+1 modulo N; last_grant updates only on a grant.
REQ-019 At most one pulse SHALL be issued per cycle; back-to-back pulses on consecutive cycles are permitted.
REQ-020 A new rising edge of deb[i] while pending[i]=1 and not being granted that edge SHALL leave pending[i]=1 and set overflow[i]=1.
REQ-021 If pending[i] is granted on the same edge a new rising edge of deb[i] arrives, pending[i] SHALL remain 1 (new event queued) and overflow[i] SHALL NOT be set.
REQ-022 overflow bits SHALL be sticky until reset.
REQ-023 When pulse=0, pulse_id SHALL hold its last value.

Reset
REQ-024 RST=1 SHALL asynchronously force pulse=0, pulse_id=0, pending=0, overflow=0, all synchronizer flops, deb bits and counters to 0, and last_grant=N-1 (button 0 highest priority first).
REQ-025 Deassertion of RST SHALL take effect at the next CLK edge; a button already held at release SHALL produce one pulse after the REQ-015 latency.
REQ-026 RST asserted mid-debounce or with events pending SHALL discard them with no pulse emitted.

Verification
REQ-027 Single press: N=4, DEBOUNCE=4, ready=1, button[2] rises before edge 0 and holds -> pulse=1 with pulse_id=2 for exactly the cycle after edge 7, then pulse=0.
REQ-028 Bounce rejection: button[0] high for 3 cycles, low 1 cycle, high again and held -> exactly one pulse, id 0, 8 edges after the final rise.
REQ-029 Round-robin: buttons 0,1,3 pressed on the same edge, ready=1 -> pulses on three consecutive cycles with ids 0,1,3; a repeat of the same stimulus -> ids 0,1,3 again (last_grant=3 wraps to 0).
REQ-030 Backpressure: ready=0 while button[1] is pressed, released and pressed again -> pending[1]=1, overflow[1]=1, no pulse; ready=1 -> one pulse with id 1, then pending=0.
REQ-031 Reset mid-operation: pending=4'b1010 and RST pulsed high between clock edges -> pending, overflow and pulse read 0 immediately; no pulse follows release while buttons stay low.
REQ-032 Release only: a held button released -> no pulse on the falling debounced edge.
